// File: rtl/min_control_sequencer.sv
// min_control_sequencer
//   Microcoded-style control sequencer for a small accumulator datapath.
//   Walks FETCH -> DECODE -> (OPF1 -> (OPF2)) -> EXEC -> WB and emits a
//   registered 18-bit control word per state.
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   ire[15:0]  instruction register: [15:12] opcode, [11:10] mode, [3:0] cond mask
//   cc[3:0]    condition codes {z,v,n,c}
//   mem_ready  memory access complete (only used with wait states enabled)
//   cntrl_wrd  registered datapath control word
//   mem_req    registered memory request
//   state      current FSM state encoding
//   halted     high while in HALT
//
// Configuration
//   MIN_SEQ_WAITSTATE_EN  when defined, FETCH/OPF1/OPF2 hold until an access
//                         completes (mem_req && mem_ready); when undefined,
//                         mem_ready is ignored and each memory state takes one cycle.
module min_control_sequencer #(
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter logic [3:0] BR_OP   = 4'hE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ire,
  input  logic [3:0]  cc,
  input  logic        mem_ready,
  output logic [17:0] cntrl_wrd,
  output logic        mem_req,
  output logic [2:0]  state,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_OPF1   = 3'd3,
    ST_OPF2   = 3'd4,
    ST_EXEC   = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  // Control word bit positions
  localparam int PC_INC  = 17;
  localparam int PC_LOAD = 16;
  localparam int IR_LOAD = 15;
  localparam int MEM_RD  = 14;
  localparam int T1_LOAD = 12;
  localparam int T2_LOAD = 11;
  localparam int RX_WE   = 10;
  localparam int CC_WE   = 9;
  localparam int AO_LOAD = 0;

  state_t      state_q, state_d;
  logic [17:0] cntrl_wrd_q, cntrl_wrd_d;
  logic        mem_req_q, mem_req_d;
  logic        halted_q, halted_d;

  logic [3:0]  opcode;
  logic [1:0]  mode;
  logic        access_done;
  logic        br_taken;
  logic        unused_ire;

  assign opcode     = ire[15:12];
  assign mode       = ire[11:10];
  assign br_taken   = |(ire[3:0] & cc);
  assign unused_ire = ^ire[9:4];

`ifdef MIN_SEQ_WAITSTATE_EN
  // An access only completes while our registered request is visible.
  assign access_done = mem_req_q & mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign access_done      = 1'b1;
`endif

  // State and registered outputs; reset abandons any pending access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RST;
      cntrl_wrd_q <= '0;
      mem_req_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cntrl_wrd_q <= cntrl_wrd_d;
      mem_req_q   <= mem_req_d;
      halted_q    <= halted_d;
    end
  end

  // Next-state logic. Branches skip operand fetch and go straight to EXEC.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH:  if (access_done) state_d = ST_DECODE;
      ST_DECODE: begin
        if (opcode == HALT_OP)    state_d = ST_HALT;
        else if (opcode == BR_OP) state_d = ST_EXEC;
        else begin
          unique case (mode)
            2'b00:   state_d = ST_EXEC;
            2'b01:   state_d = ST_OPF1;
            2'b10:   state_d = ST_OPF1;
            default: state_d = ST_FETCH;
          endcase
        end
      end
      ST_OPF1: begin
        if (access_done) state_d = (mode == 2'b10) ? ST_OPF2 : ST_EXEC;
      end
      ST_OPF2:   if (access_done) state_d = ST_EXEC;
      ST_EXEC:   state_d = (opcode == BR_OP) ? ST_FETCH : ST_WB;
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_RST;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the cycle in which state_q shows that state. While a memory state
  // holds, the same inputs decode to the same word, keeping it stable.
  always_comb begin
    cntrl_wrd_d = '0;
    mem_req_d   = 1'b0;
    halted_d    = 1'b0;
    unique case (state_d)
      ST_FETCH: begin
        mem_req_d            = 1'b1;
        cntrl_wrd_d[MEM_RD]  = 1'b1;
        cntrl_wrd_d[IR_LOAD] = 1'b1;
        cntrl_wrd_d[PC_INC]  = 1'b1;
      end
      ST_OPF1: begin
        mem_req_d            = 1'b1;
        cntrl_wrd_d[MEM_RD]  = 1'b1;
        cntrl_wrd_d[T1_LOAD] = 1'b1;
        cntrl_wrd_d[PC_INC]  = 1'b1;
      end
      ST_OPF2: begin
        mem_req_d            = 1'b1;
        cntrl_wrd_d[MEM_RD]  = 1'b1;
        cntrl_wrd_d[T2_LOAD] = 1'b1;
        cntrl_wrd_d[4:3]     = 2'b01;
      end
      ST_EXEC: begin
        if (opcode == BR_OP) begin
          cntrl_wrd_d[PC_LOAD] = br_taken;
        end else begin
          cntrl_wrd_d[8:5]     = opcode;
          cntrl_wrd_d[AO_LOAD] = 1'b1;
          cntrl_wrd_d[CC_WE]   = 1'b1;
          unique case (mode)
            2'b01:   cntrl_wrd_d[2:1] = 2'b01;
            2'b10:   cntrl_wrd_d[2:1] = 2'b10;
            default: cntrl_wrd_d[2:1] = 2'b00;
          endcase
        end
      end
      ST_WB:   cntrl_wrd_d[RX_WE] = 1'b1;
      ST_HALT: halted_d = 1'b1;
      default: ;
    endcase
  end

  assign cntrl_wrd = cntrl_wrd_q;
  assign mem_req   = mem_req_q;
  assign halted    = halted_q;
  assign state     = state_q;

endmodule

// File: doc/min_control_sequencer.md
MIN_CONTROL_SEQUENCER -- requirements
Module: min_control_sequencer

Interface
REQ-001 Parameter HALT_OP, default 4'hF, opcode that sends the FSM to HALT.
REQ-002 Parameter BR_OP, default 4'hE, conditional branch opcode.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ire  input  16  instruction register; [15:12] opcode, [11:10] addressing mode, [3:0] branch condition mask.
REQ-006 cc  input  4  condition codes {z,v,n,c} from the execution unit.
REQ-007 mem_ready  input  1  memory access complete.
REQ-008 cntrl_wrd  output  18  registered datapath control word.
REQ-009 mem_req  output  1  memory access request, registered.
REQ-010 state  output  3  current FSM state encoding.
REQ-011 halted  output  1  high while in HALT.

Function
REQ-012 States, with encodings: RST=0, FETCH=1, DECODE=2, OPF1=3, OPF2=4, EXEC=5, WB=6, HALT=7.
REQ-013 cntrl_wrd fields: [17] pc_inc, [16] pc_load, [15] ir_load, [14] mem_rd, [13] mem_wr, [12] t1_load, [11] t2_load, [10] rx_we, [9] cc_we, [8:5] alu_op, [4:3] a_sel, [2:1] b_sel, [0] ao_load.
REQ-014 RST -> FETCH unconditionally on the first cycle after reset deasserts.
REQ-015 FETCH: mem_req=1, mem_rd=1, ir_load=1, pc_inc=1; advance to DECODE on an access-complete cycle (REQ-027/028).
REQ-016 DECODE: cntrl_wrd=0. Next state: opcode==HALT_OP -> HALT; mode 00 -> EXEC; mode 01 -> OPF1; mode 10 -> OPF1; mode 11 -> FETCH (illegal mode; no write occurs).
REQ-017 OPF1: mem_rd=1, mem_req=1, t1_load=1, pc_inc=1; on completion, mode 01 -> EXEC, mode 10 -> OPF2.
REQ-018 OPF2: mem_rd=1, mem_req=1, t2_load=1, using t1 as the address (a_sel=2'b01); on completion -> EXEC.
REQ-019 EXEC: alu_op=opcode, ao_load=1, cc_we=1, b_sel=2'b00 for mode 00, 2'b01 for mode 01 and 2'b10 for mode 10; next -> WB. Exception: for BR_OP, EXEC asserts only pc_load, and only when (ire[3:0] & cc) != 0; cc_we=0 and ao_load=0; next -> FETCH.
REQ-020 WB: rx_we=1 for one cycle; next -> FETCH.
REQ-021 HALT: cntrl_wrd=0, mem_req=0, halted=1; the FSM leaves HALT only on reset.
REQ-022 cntrl_wrd, mem_req and halted are registered and become valid in the same cycle that state shows the corresponding state.
REQ-023 Latency from FETCH entry to the next FETCH with zero wait states: 4 cycles for mode 00, 5 for mode 01, 6 for mode 10, 3 for a branch, 2 for mode 11.
REQ-024 mem_wr is 0 in every state. The bit is reserved for store opcodes.
REQ-025 Only one memory request is outstanding at a time. mem_req stays high and the rest of cntrl_wrd stays stable until the access completes.

Reset
REQ-026 When reset=1 at a rising edge: state=RST, cntrl_wrd=0, mem_req=0, halted=0. This holds in every state, including mid-wait and HALT; a pending access is abandoned without completing.

Configuration
REQ-027 Macro MIN_SEQ_WAITSTATE_EN defined: an access completes only in a cycle with mem_req=1 and mem_ready=1, and FETCH, OPF1 and OPF2 hold until then.
REQ-028 Macro MIN_SEQ_WAITSTATE_EN undefined: mem_ready is ignored and every memory state lasts exactly one cycle.

Verification
REQ-029 Reset pulse, then ire=16'h0462 (opcode 0, mode 01), mem_ready=1 -> state sequence RST, FETCH, DECODE, OPF1, EXEC, WB, FETCH; rx_we=1 only in WB.
REQ-030 ire=16'hE001, cc=4'b0001 -> EXEC asserts pc_load=1. With cc=4'b1000 -> pc_load=0 and the FSM returns to FETCH.
REQ-031 ire=16'hF000 -> HALT after DECODE, halted=1 held for 20 cycles; a reset pulse returns the FSM to RST and then FETCH.
REQ-032 MIN_SEQ_WAITSTATE_EN defined, mem_ready held low for 3 cycles in FETCH -> FETCH lasts 4 cycles with cntrl_wrd constant.
REQ-033 Reset asserted during OPF2 of ire=16'h0800 -> next cycle state=RST, mem_req=0, cntrl_wrd=18'h0.
REQ-034 ire=16'h0C00 (mode 11) -> DECODE goes to FETCH; rx_we, cc_we and ao_load stay 0 throughout.
